// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings,
// buffer geometry and the buffered {pc, instruction} entry type.
package instruction_fetch_pkg;

  // Fetch FSM encodings
  localparam logic [1:0] IDLE    = 2'd0;  // no request outstanding
  localparam logic [1:0] REQUEST = 2'd1;  // waiting for an ack with live data
  localparam logic [1:0] DISCARD = 2'd2;  // waiting for an ack whose data is stale

  // Instruction buffer geometry
  localparam int               FIFO_DEPTH = 2;
  localparam int               COUNT_W    = 2;
  localparam logic [COUNT_W-1:0] FIFO_FULL = COUNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally modulo 2^32
  function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fifo.sv
// Two-entry instruction buffer with push, pop, flush and occupancy count.
// Flush wins over push and pop in the same cycle.
module instruction_fifo
  import instruction_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       push_entry,
  output fetch_entry_t       head,
  output logic [COUNT_W-1:0] count
);

  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               do_push, do_pop;
  fetch_entry_t       entry_vec [FIFO_DEPTH];

  // Pointer and occupancy bookkeeping
  always_comb begin
    do_push  = push && ((count_q != FIFO_FULL) || pop);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + {{(COUNT_W-1){1'b0}}, do_push} - {{(COUNT_W-1){1'b0}}, do_pop};
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      fetch_entry_t entry_q;
      // Storage slot, written when the write pointer selects it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_q <= '0;
        end else if (do_push && !flush && (wr_ptr_q == 1'(gi))) begin
          entry_q <= push_entry;
        end
      end
      assign entry_vec[gi] = entry_q;
    end
  endgenerate

  assign head  = entry_vec[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues single-outstanding word fetches, buffers
// returned words in a two-entry FIFO, and handles redirects, stale-ack
// discarding and the sticky misaligned-target fault.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [31:0] fetchAddress,
  output logic        fetchRequest,
  input  logic        fetchAck,
  input  logic [31:0] fetchData,
  output logic [31:0] currentInstruction,
  output logic [31:0] currentPC,
  output logic        isNOP,
  input  logic        stall,
  input  logic        jumpEnable,
  input  logic [31:0] jumpAddress,
  output logic        addressMisaligned
);

  logic [1:0]         state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic               fault_q, fault_d;

  logic               fifo_push, fifo_pop, fifo_empty;
  logic [COUNT_W-1:0] fifo_count, count_after;
  fetch_entry_t       fifo_head;
  logic               can_issue, ack_live;

  // Next-state, fetch PC and request address computation
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    fault_d    = fault_q;

    fifo_empty  = (fifo_count == '0);
    ack_live    = (state_q == REQUEST) && fetchAck && !jumpEnable;
    fifo_push   = ack_live;
    fifo_pop    = !fifo_empty && !stall && !jumpEnable;
    count_after = fifo_count + {{(COUNT_W-1){1'b0}}, fifo_push}
                             - {{(COUNT_W-1){1'b0}}, fifo_pop};
    // A new request needs room for its word once the current one lands
    can_issue   = enable && !fault_q && !jumpEnable && (count_after < FIFO_FULL);

    if (ack_live) begin
      pc_d = next_fetch_pc(pc_q);
    end
    if (jumpEnable) begin
      pc_d    = jumpAddress;
      fault_d = fault_q | (jumpAddress[1:0] != 2'b00);
    end

    case (state_q)
      IDLE: begin
        if (can_issue) begin
          state_d    = REQUEST;
          req_addr_d = pc_q;
        end
      end
      REQUEST: begin
        if (jumpEnable) begin
          state_d = fetchAck ? IDLE : DISCARD;
        end else if (fetchAck) begin
          if (can_issue) begin
            state_d    = REQUEST;
            req_addr_d = pc_d;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (fetchAck) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      req_addr_q <= RESET_VECTOR;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      fault_q    <= fault_d;
    end
  end

  instruction_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .flush      (jumpEnable),
    .push_entry ('{pc: req_addr_q, instr: fetchData}),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  assign fetchRequest       = (state_q != IDLE);
  assign fetchAddress       = req_addr_q;
  assign isNOP              = fifo_empty;
  assign currentInstruction = fifo_empty ? 32'h0 : fifo_head.instr;
  assign currentPC          = fifo_empty ? 32'h0 : fifo_head.pc;
  assign addressMisaligned  = fault_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  fetch permitted; 0 blocks new requests only.
REQ-005 SHALL have port fetchAddress  output  32  word address of current request.
REQ-006 SHALL have port fetchRequest  output  1  request valid; held until fetchAck.
REQ-007 SHALL have port fetchAck  input  1  one-cycle pulse completing a request, data on fetchData.
REQ-008 SHALL have port fetchData  input  32  instruction word, sampled only when fetchAck=1.
REQ-009 SHALL have port currentInstruction  output  32  head-of-buffer instruction for the decoder.
REQ-010 SHALL have port currentPC  output  32  address of currentInstruction.
REQ-011 SHALL have port isNOP  output  1  1 when buffer empty (no valid instruction presented).
REQ-012 SHALL have port stall  input  1  downstream not consuming this cycle.
REQ-013 SHALL have port jumpEnable  input  1  one-cycle redirect strobe.
REQ-014 SHALL have port jumpAddress  input  32  redirect target, sampled when jumpEnable=1.
REQ-015 SHALL have port addressMisaligned  output  1  sticky fault, misaligned redirect target.

Function
REQ-016 SHALL hold a 2-entry FIFO of {pc, instruction}; head drives currentPC/currentInstruction.
REQ-017 SHALL drive isNOP=1 and currentInstruction=32'h0 whenever FIFO is empty.
REQ-018 SHALL pop head at the edge where isNOP=0 and stall=0; stall=1 holds outputs unchanged.
REQ-019 SHALL allow at most one outstanding request; SHALL assert fetchRequest only when enable=1, no fault, and (FIFO count + outstanding) < 2, counting a same-cycle pop as freeing a slot.
REQ-020 SHALL keep fetchAddress/fetchRequest stable from assertion until fetchAck.
REQ-021 SHALL push {fetchAddress, fetchData} on fetchAck (unless discarding) and advance fetch PC by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-022 SHALL make an acked word visible (isNOP=0) in the cycle after fetchAck; zero-wait ack gives 1 instruction per cycle sustained.
REQ-023 SHALL use states IDLE (no request), REQUEST (awaiting ack), DISCARD (awaiting ack whose data is stale).
REQ-024 SHALL transition IDLE->REQUEST when REQ-019 allows; REQUEST->IDLE or REQUEST->REQUEST (back-to-back) on fetchAck; REQUEST->DISCARD on jumpEnable without fetchAck; DISCARD->IDLE on fetchAck, dropping data.
REQ-025 SHALL on jumpEnable flush FIFO (isNOP=1 next cycle), ignore same-cycle pop, and set fetch PC to jumpAddress.
REQ-026 SHALL on simultaneous jumpEnable and fetchAck drop the acked word and go to IDLE.
REQ-027 SHALL on jumpEnable with jumpAddress[1:0]!=0 set addressMisaligned, flush FIFO, and issue no further requests until reset (outstanding ack still absorbed).
REQ-028 SHALL ignore fetchAck in IDLE.

Reset
REQ-029 SHALL while rst_n=0 force: state IDLE, FIFO empty, fetch PC=RESET_VECTOR, fetchRequest=0, fetchAddress=RESET_VECTOR, isNOP=1, currentInstruction=0, currentPC=0, addressMisaligned=0.
REQ-030 SHALL abandon any outstanding request on reset; first request after release targets RESET_VECTOR.

Structure
REQ-031 SHALL place state encodings (IDLE/REQUEST/DISCARD) and FIFO_DEPTH=2 in a shared core package.
REQ-032 SHALL implement the buffer as sub-module instruction_fifo (2-entry, push/pop/flush, count).

Verification
REQ-033 Reset release, enable=1, RESET_VECTOR=32'h100, zero-wait ack data 32'h00000013 -> fetchAddress 100,104,108; isNOP=0 from cycle after first ack, currentPC=32'h100.
REQ-034 stall=1 for 5 cycles with acks available -> exactly 2 words buffered, fetchRequest=0, outputs frozen; stall release -> pops in order 100,104.
REQ-035 jumpEnable, jumpAddress=32'h200 while request to 108 outstanding, ack 3 cycles later -> word for 108 dropped, next request 200, next presented currentPC=32'h200.
REQ-036 jumpEnable coincident with fetchAck -> acked word never appears; next request to jumpAddress.
REQ-037 jumpAddress=32'h202 -> addressMisaligned=1, isNOP=1, fetchRequest stays 0 until rst_n pulse.
REQ-038 fetch PC 32'hFFFF_FFFC acked -> next fetchAddress 32'h0000_0000.
